// File: rtl/gold_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// gold_ctrl_pkg
// Shared types for the gold pickup sequencer and its helpers.
//   gold_state_t  - sequencer state, also exported on the debug/HUD port
//   rr_prio_t     - which tank wins a same-cycle double take
//   tile_t        - 5-bit tile coordinate (pixel top-left = tile * TILE_SIZE)
//   frame_cnt_t   - 10-bit saturating frame/retry counter
//   tile_in_range - true when a drawn tile lies on the visible playfield
// -----------------------------------------------------------------------------
package gold_ctrl_pkg;

  localparam int TILE_SIZE = 32;

  typedef logic [4:0] tile_t;
  typedef logic [9:0] frame_cnt_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT    = 3'd1,
    PICK    = 3'd2,
    CHECK   = 3'd3,
    ACTIVE  = 3'd4,
    COLLECT = 3'd5
  } gold_state_t;

  typedef enum logic {
    PRIO_TANK1 = 1'b0,
    PRIO_TANK2 = 1'b1
  } rr_prio_t;

  // The random sources span 0..31 while the playfield is smaller, so a draw
  // can land off-map and must be redrawn.
  function automatic logic tile_in_range(input tile_t x, input tile_t y,
                                         input int cols, input int rows);
    return (int'(x) < cols) && (int'(y) < rows);
  endfunction

endpackage

// File: rtl/frame_countdown.sv
// -----------------------------------------------------------------------------
// frame_countdown
// Frame-gated up-counter shared by the timed pickups. Counts one step per
// start-of-frame pulse while enabled, saturates at all-ones instead of
// wrapping, and flags the frame on which the count sits at the caller's limit.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   sof         - 1-cycle start-of-frame pulse
//   enable      - counting allowed this cycle
//   clear       - restart from zero (wins over counting)
//   limit       - terminal value to compare against
//   count_next  - value the counter takes at the coming edge
//   at_limit    - SOF seen while enabled with the count equal to limit
// -----------------------------------------------------------------------------
module frame_countdown
  import gold_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       sof,
  input  logic       enable,
  input  logic       clear,
  input  frame_cnt_t limit,
  output frame_cnt_t count_next,
  output logic       at_limit
);

  frame_cnt_t count;

  // NOTE: every signal assigned in an always_comb gets a default on the first
  // line, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    count_next = count;
    if (clear) begin
      count_next = '0;
    end else if (enable && sof && (count != '1)) begin
      count_next = count + frame_cnt_t'(1);
    end
  end

  assign at_limit = enable && sof && (count == limit);

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

endmodule

// File: rtl/gold_spawn_controller.sv
// -----------------------------------------------------------------------------
// gold_spawn_controller
// Sequences the single gold pickup on the tile playfield: waits a respawn
// delay, draws random candidate tiles (redrawing off-map ones, retrying
// blocked ones a bounded number of times), commits the tile, keeps the gold
// visible with a blink near the end of its lifetime, and awards exactly one
// tank per pickup with round-robin tie-breaking.
// Ports:
//   clk, reset                - clock, synchronous active-high reset
//   startOfFrame              - 1-cycle pulse per VGA frame
//   game_active               - level running; low forces IDLE
//   randomX, randomY          - free-running random tile coordinates
//   tile_blocked              - combinational map lookup of cand_tileX/Y
//   gold_take1, gold_take2    - tank collision levels
//   cand_tileX, cand_tileY    - candidate tile presented to the map lookup
//   gold_tileX, gold_tileY    - committed gold tile
//   gold_visible              - drawer enable
//   gold_up                   - 1-cycle pulse on spawn commit
//   award1, award2            - 1-cycle pulse per collected gold
//   gold_state                - current sequencer state
// All outputs are registered.
// -----------------------------------------------------------------------------
module gold_spawn_controller
  import gold_ctrl_pkg::*;
#(
  parameter int TILE_COLS       = 20,
  parameter int TILE_ROWS       = 15,
  parameter int RESPAWN_FRAMES  = 180,
  parameter int LIFETIME_FRAMES = 600,
  parameter int BLINK_FRAMES    = 120,
  parameter int MAX_RETRIES     = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        startOfFrame,
  input  logic        game_active,
  input  logic [4:0]  randomX,
  input  logic [4:0]  randomY,
  input  logic        tile_blocked,
  input  logic        gold_take1,
  input  logic        gold_take2,
  output logic [4:0]  cand_tileX,
  output logic [4:0]  cand_tileY,
  output logic [4:0]  gold_tileX,
  output logic [4:0]  gold_tileY,
  output logic        gold_visible,
  output logic        gold_up,
  output logic        award1,
  output logic        award2,
  output logic [2:0]  gold_state
);

  localparam frame_cnt_t RESPAWN_LAST  = frame_cnt_t'(RESPAWN_FRAMES - 1);
  localparam frame_cnt_t LIFETIME_LAST = frame_cnt_t'(LIFETIME_FRAMES - 1);
  localparam frame_cnt_t BLINK_START   = frame_cnt_t'(LIFETIME_FRAMES - BLINK_FRAMES);
  localparam frame_cnt_t RETRY_LAST    = frame_cnt_t'(MAX_RETRIES - 1);

  gold_state_t state_q, state_d;
  frame_cnt_t  retry_q;
  rr_prio_t    rr_prio_q;

  frame_cnt_t  frame_next;
  frame_cnt_t  frame_limit;
  logic        frame_tc;
  logic        frame_clear;
  logic        frame_enable;

  logic        cand_load;
  logic        commit;
  logic        retry_clear;
  logic        retry_inc;
  logic        win1;
  logic        win2;
  logic        tie;
  logic        visible_d;

  // One counter serves both timed states; the limit follows the state.
  assign frame_limit  = (state_q == WAIT) ? RESPAWN_LAST : LIFETIME_LAST;
  assign frame_enable = (state_q == WAIT) || (state_q == ACTIVE);
  // Every state change restarts the frame count, which covers all the
  // "frame_cnt=0" entries into WAIT and ACTIVE.
  assign frame_clear  = (state_d != state_q);

  frame_countdown u_frame_countdown (
    .clk        (clk),
    .reset      (reset),
    .sof        (startOfFrame),
    .enable     (frame_enable),
    .clear      (frame_clear),
    .limit      (frame_limit),
    .count_next (frame_next),
    .at_limit   (frame_tc)
  );

  always_comb begin
    state_d     = state_q;
    cand_load   = 1'b0;
    commit      = 1'b0;
    retry_clear = 1'b0;
    retry_inc   = 1'b0;
    win1        = 1'b0;
    win2        = 1'b0;
    tie         = 1'b0;

    if (!game_active) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: state_d = WAIT;

        WAIT: begin
          if (frame_tc) begin
            state_d     = PICK;
            retry_clear = 1'b1;
          end
        end

        PICK: begin
          // Off-map draws loop here without touching the retry budget.
          cand_load = 1'b1;
          if (tile_in_range(randomX, randomY, TILE_COLS, TILE_ROWS)) begin
            state_d = CHECK;
          end
        end

        CHECK: begin
          if (tile_blocked) begin
            retry_inc = 1'b1;
            state_d   = (retry_q == RETRY_LAST) ? WAIT : PICK;
          end else begin
            commit  = 1'b1;
            state_d = ACTIVE;
          end
        end

        ACTIVE: begin
          // A take on the expiry frame still wins, so it is tested first.
          if (gold_take1 || gold_take2) begin
            state_d = COLLECT;
            tie     = gold_take1 && gold_take2;
            if (tie) begin
              win1 = (rr_prio_q == PRIO_TANK1);
              win2 = (rr_prio_q == PRIO_TANK2);
            end else begin
              win1 = gold_take1;
              win2 = gold_take2;
            end
          end else if (frame_tc) begin
            state_d = WAIT;
          end
        end

        COLLECT: begin
          // Hold until both collisions drop so a lingering overlap cannot
          // collect the next gold by accident.
          if (!gold_take1 && !gold_take2) begin
            state_d = WAIT;
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  // Visibility is computed from the post-edge state and count so the drawer
  // enable lines up with gold_state on the same cycle. The blink toggles
  // every 8 frames via bit 3 of the lifetime count.
  assign visible_d = (state_d == ACTIVE) &&
                     ((frame_next < BLINK_START) || !frame_next[3]);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      retry_q      <= '0;
      rr_prio_q    <= PRIO_TANK1;
      cand_tileX   <= '0;
      cand_tileY   <= '0;
      gold_tileX   <= '0;
      gold_tileY   <= '0;
      gold_visible <= 1'b0;
      gold_up      <= 1'b0;
      award1       <= 1'b0;
      award2       <= 1'b0;
    end else begin
      state_q      <= state_d;
      gold_visible <= visible_d;
      gold_up      <= commit;
      award1       <= win1;
      award2       <= win2;

      if (cand_load) begin
        cand_tileX <= randomX;
        cand_tileY <= randomY;
      end

      if (commit) begin
        gold_tileX <= cand_tileX;
        gold_tileY <= cand_tileY;
      end

      if (retry_clear) begin
        retry_q <= '0;
      end else if (retry_inc && (retry_q != '1)) begin
        retry_q <= retry_q + frame_cnt_t'(1);
      end

      // The tank that lost a tie gets priority on the next tie.
      if (tie) begin
        rr_prio_q <= (rr_prio_q == PRIO_TANK1) ? PRIO_TANK2 : PRIO_TANK1;
      end
    end
  end

  assign gold_state = state_q;

endmodule

// File: tb/tb_gold_spawn_controller.sv
// -----------------------------------------------------------------------------
// tb_gold_spawn_controller
// Self-checking bench: a directed vector table for the first spawns, hand
// sequences for multi-cycle corner cases, then randomized stimulus. Every
// cycle the DUT outputs are also compared with a behavioural model.
// -----------------------------------------------------------------------------
module tb_gold_spawn_controller;

  localparam int COLS    = 20;
  localparam int ROWS    = 15;
  localparam int RESPAWN = 3;
  localparam int LIFE    = 10;
  localparam int BLINK   = 4;
  localparam int MAXR    = 2;

  localparam int S_IDLE    = 0;
  localparam int S_WAIT    = 1;
  localparam int S_PICK    = 2;
  localparam int S_CHECK   = 3;
  localparam int S_ACTIVE  = 4;
  localparam int S_COLLECT = 5;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sof = 1'b0;
  logic       ga = 1'b0;
  logic [4:0] rx = '0;
  logic [4:0] ry = '0;
  logic       blk_force = 1'b0;
  logic [1023:0] blk_map = '0;
  logic       tile_blocked;
  logic       t1 = 1'b0;
  logic       t2 = 1'b0;
  logic [4:0] cand_x, cand_y, gold_x, gold_y;
  logic       vis, up, a1, a2;
  logic [2:0] st;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Map lookup: combinational on the DUT's candidate tile.
  assign tile_blocked = blk_force | blk_map[{cand_x, cand_y}];

  gold_spawn_controller #(
    .TILE_COLS       (COLS),
    .TILE_ROWS       (ROWS),
    .RESPAWN_FRAMES  (RESPAWN),
    .LIFETIME_FRAMES (LIFE),
    .BLINK_FRAMES    (BLINK),
    .MAX_RETRIES     (MAXR)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .startOfFrame (sof),
    .game_active  (ga),
    .randomX      (rx),
    .randomY      (ry),
    .tile_blocked (tile_blocked),
    .gold_take1   (t1),
    .gold_take2   (t2),
    .cand_tileX   (cand_x),
    .cand_tileY   (cand_y),
    .gold_tileX   (gold_x),
    .gold_tileY   (gold_y),
    .gold_visible (vis),
    .gold_up      (up),
    .award1       (a1),
    .award2       (a2),
    .gold_state   (st)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- behavioural reference model ----------------
  int m_phase = S_IDLE;
  int m_frames = 0;
  int m_tries = 0;
  bit m_prio_t2 = 1'b0;
  int m_cx = 0, m_cy = 0, m_gx = 0, m_gy = 0;
  bit m_up = 0, m_vis = 0, m_a1 = 0, m_a2 = 0;

  function automatic void goto_phase(input int p);
    if (p != m_phase) m_frames = 0;
    m_phase = p;
  endfunction

  task automatic model_step();
    bit blocked;
    m_up = 0; m_a1 = 0; m_a2 = 0;
    if (reset) begin
      m_phase = S_IDLE; m_frames = 0; m_tries = 0; m_prio_t2 = 0;
      m_cx = 0; m_cy = 0; m_gx = 0; m_gy = 0; m_vis = 0;
      return;
    end
    if (!ga) begin
      goto_phase(S_IDLE);
    end else begin
      case (m_phase)
        S_IDLE: goto_phase(S_WAIT);
        S_WAIT:
          if (sof) begin
            if (m_frames == RESPAWN - 1) begin m_tries = 0; goto_phase(S_PICK); end
            else if (m_frames < 1023) m_frames++;
          end
        S_PICK: begin
          m_cx = int'(rx); m_cy = int'(ry);
          if (m_cx < COLS && m_cy < ROWS) goto_phase(S_CHECK);
        end
        S_CHECK: begin
          blocked = blk_force || blk_map[m_cx * 32 + m_cy];
          if (blocked) begin
            if (m_tries == MAXR - 1) goto_phase(S_WAIT);
            else goto_phase(S_PICK);
            m_tries++;
          end else begin
            m_gx = m_cx; m_gy = m_cy; m_up = 1;
            goto_phase(S_ACTIVE);
          end
        end
        S_ACTIVE:
          if (t1 || t2) begin
            if (t1 && t2) begin
              if (m_prio_t2) m_a2 = 1; else m_a1 = 1;
              m_prio_t2 = !m_prio_t2;
            end else begin
              m_a1 = t1; m_a2 = t2;
            end
            goto_phase(S_COLLECT);
          end else if (sof) begin
            if (m_frames == LIFE - 1) goto_phase(S_WAIT);
            else m_frames++;
          end
        S_COLLECT: if (!t1 && !t2) goto_phase(S_WAIT);
        default: goto_phase(S_IDLE);
      endcase
    end
    m_vis = (m_phase == S_ACTIVE) &&
            ((m_frames < LIFE - BLINK) || ((m_frames / 8) % 2 == 0));
  endtask

  task automatic tick();
    logic [26:0] got, want;
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    got  = {st, up, vis, a1, a2, gold_x, gold_y, cand_x, cand_y};
    want = {3'(m_phase), m_up, m_vis, m_a1, m_a2, 5'(m_gx), 5'(m_gy), 5'(m_cx), 5'(m_cy)};
    check("model {state,up,vis,a1,a2,gx,gy,cx,cy}", 32'(got), 32'(want));
  endtask

  task automatic sof_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      sof = 1'b1; tick();
      sof = 1'b0; tick();
    end
  endtask

  // From WAIT with a fresh count: respawn and commit tile (x,y).
  task automatic spawn(input logic [4:0] x, input logic [4:0] y);
    rx = 5'd31; ry = 5'd0;
    sof_pulses(RESPAWN);
    rx = x; ry = y;
    tick();
    tick();
    check("spawn state", 32'(st), S_ACTIVE);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic       ga, sof;
    logic [4:0] rx, ry;
    logic       blk, t1, t2;
    logic [2:0] st;
    logic       up, vis, a1, a2;
    logic [4:0] gx, gy;
  } vec_t;

  vec_t vecs[19];

  int a1_cnt, a2_cnt, up_cnt;
  logic [9:1] blink_exp;

  initial begin
    vecs[0]  = '{1,0, 0, 0,0,0,0, S_WAIT,   0,0,0,0, 0,0};
    vecs[1]  = '{1,1, 0, 0,0,0,0, S_WAIT,   0,0,0,0, 0,0};
    vecs[2]  = '{1,0, 0, 0,0,0,0, S_WAIT,   0,0,0,0, 0,0};
    vecs[3]  = '{1,1, 0, 0,0,0,0, S_WAIT,   0,0,0,0, 0,0};
    vecs[4]  = '{1,0, 0, 0,0,0,0, S_WAIT,   0,0,0,0, 0,0};
    vecs[5]  = '{1,1, 0, 0,0,0,0, S_PICK,   0,0,0,0, 0,0};
    vecs[6]  = '{1,0, 5, 7,0,0,0, S_CHECK,  0,0,0,0, 0,0};
    vecs[7]  = '{1,0, 5, 7,0,0,0, S_ACTIVE, 1,1,0,0, 5,7};
    vecs[8]  = '{1,0, 5, 7,0,0,0, S_ACTIVE, 0,1,0,0, 5,7};
    vecs[9]  = '{1,0, 5, 7,0,1,0, S_COLLECT,0,0,1,0, 5,7};
    vecs[10] = '{1,0, 5, 7,0,0,0, S_WAIT,   0,0,0,0, 5,7};
    vecs[11] = '{1,1, 5, 7,0,0,0, S_WAIT,   0,0,0,0, 5,7};
    vecs[12] = '{1,0, 5, 7,0,0,0, S_WAIT,   0,0,0,0, 5,7};
    vecs[13] = '{1,1, 5, 7,0,0,0, S_WAIT,   0,0,0,0, 5,7};
    vecs[14] = '{1,1, 5, 7,0,0,0, S_PICK,   0,0,0,0, 5,7};
    vecs[15] = '{1,0,25, 3,0,0,0, S_PICK,   0,0,0,0, 5,7};
    vecs[16] = '{1,0, 4,20,0,0,0, S_PICK,   0,0,0,0, 5,7};
    vecs[17] = '{1,0, 2, 2,0,0,0, S_CHECK,  0,0,0,0, 5,7};
    vecs[18] = '{1,0, 2, 2,0,0,0, S_ACTIVE, 1,1,0,0, 2,2};

    // Reset state
    reset = 1'b1;
    tick(); tick();
    check("reset state", 32'(st), S_IDLE);
    check("reset outputs", 32'({vis, up, a1, a2, gold_x, gold_y, cand_x, cand_y}), 0);
    reset = 1'b0;

    // Spawn at (5,7), collect, then off-map redraws before committing (2,2)
    for (int i = 0; i < 19; i++) begin
      ga = vecs[i].ga; sof = vecs[i].sof; rx = vecs[i].rx; ry = vecs[i].ry;
      blk_force = vecs[i].blk; t1 = vecs[i].t1; t2 = vecs[i].t2;
      tick();
      check($sformatf("vec%0d state", i), 32'(st), 32'(vecs[i].st));
      check($sformatf("vec%0d up/vis/a1/a2", i), 32'({up, vis, a1, a2}),
            32'({vecs[i].up, vecs[i].vis, vecs[i].a1, vecs[i].a2}));
      check($sformatf("vec%0d gold tile", i), 32'({gold_x, gold_y}),
            32'({vecs[i].gx, vecs[i].gy}));
    end
    sof = 1'b0; blk_force = 1'b0;

    // Held take: one award only, COLLECT until released
    t1 = 1'b1; a1_cnt = 0;
    for (int i = 0; i < 5; i++) begin tick(); a1_cnt += int'(a1); end
    check("held take award count", 32'(a1_cnt), 1);
    check("held take state", 32'(st), S_COLLECT);
    t1 = 1'b0; tick();
    check("release -> WAIT", 32'(st), S_WAIT);

    // Two blocked checks abandon the attempt
    rx = 5'd31;
    sof_pulses(2);
    check("still WAIT after 2 SOF", 32'(st), S_WAIT);
    sof_pulses(1);
    check("PICK after 3rd SOF", 32'(st), S_PICK);
    rx = 5'd3; ry = 5'd4; blk_force = 1'b1; up_cnt = 0;
    for (int i = 0; i < 4; i++) begin tick(); up_cnt += int'(up); end
    check("blocked retries -> WAIT", 32'(st), S_WAIT);
    check("no gold_up when blocked", 32'(up_cnt), 0);
    blk_force = 1'b0;
    spawn(5'd9, 5'd10);
    check("respawn gold_up", 32'(up), 1);
    check("respawn tile", 32'({gold_x, gold_y}), 32'({5'd9, 5'd10}));

    // Round-robin ties across two spawns
    t1 = 1'b1; t2 = 1'b1; tick();
    check("tie1 awards", 32'({a1, a2}), 32'(2'b10));
    t1 = 1'b0; t2 = 1'b0; tick();
    spawn(5'd6, 5'd6);
    t1 = 1'b1; t2 = 1'b1; tick();
    check("tie2 awards", 32'({a1, a2}), 32'(2'b01));
    t1 = 1'b0; t2 = 1'b0; tick();

    // Lifetime with blink, then expiry without award
    spawn(5'd12, 5'd13);
    blink_exp = 9'b001111111;  // frames 9..1: frames 8,9 dark
    for (int k = 1; k <= 9; k++) begin
      sof = 1'b1; tick();
      check($sformatf("visible frame %0d", k), 32'(vis), 32'(blink_exp[k]));
      sof = 1'b0; tick();
    end
    sof = 1'b1; tick(); sof = 1'b0;
    check("expire -> WAIT", 32'(st), S_WAIT);
    check("expire no award/vis", 32'({a1, a2, vis}), 0);
    tick();

    // Take on the expiry frame wins
    spawn(5'd1, 5'd1);
    sof_pulses(LIFE - 1);
    sof = 1'b1; t1 = 1'b1; tick();
    sof = 1'b0;
    check("take+expire state", 32'(st), S_COLLECT);
    check("take+expire award1", 32'(a1), 1);
    t1 = 1'b0; tick();

    // game_active drop mid-ACTIVE
    spawn(5'd7, 5'd8);
    sof_pulses(2);
    ga = 1'b0; tick();
    check("ga=0 -> IDLE", 32'(st), S_IDLE);
    check("ga=0 visible", 32'(vis), 0);
    check("ga=0 gold held", 32'({gold_x, gold_y}), 32'({5'd7, 5'd8}));
    ga = 1'b1; tick();
    check("ga=1 -> WAIT", 32'(st), S_WAIT);
    t2 = 1'b1; tick();
    check("take outside ACTIVE ignored", 32'({a1, a2}), 0);
    t2 = 1'b0; tick();

    // Randomized run against the model
    for (int i = 0; i < 1024; i++) blk_map[i] = ($urandom_range(0, 9) < 3);
    begin
      int h1, h2, ga_off;
      h1 = 0; h2 = 0; ga_off = 0;
      for (int i = 0; i < 4000; i++) begin
        reset = ($urandom_range(0, 999) == 0);
        if (ga_off > 0) ga_off--;
        else if ($urandom_range(0, 299) == 0) ga_off = $urandom_range(1, 3);
        ga  = (ga_off == 0);
        sof = ($urandom_range(0, 2) == 0);
        rx  = 5'($urandom_range(0, 31));
        ry  = 5'($urandom_range(0, 31));
        if (h1 > 0) h1--; else if ($urandom_range(0, 15) == 0) h1 = $urandom_range(1, 6);
        if (h2 > 0) h2--; else if ($urandom_range(0, 15) == 0) h2 = $urandom_range(1, 6);
        t1 = (h1 > 0);
        t2 = (h2 > 0);
        tick();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
